// File: rtl/pbr_initiator.sv
// pbr_initiator: port-side initiator for the packet-buffer request interface.
// Writes leave through a one-entry pbrd output stage. Reads leave through a
// one-entry pbra output stage and reserve a reorder-buffer slot. The slot index
// is the txid. Read responses on pbrr fill their slot, and the port drains the
// slots strictly in issue order.
module pbr_initiator #(
    parameter int width   = 64,
    parameter int asz     = 8,
    parameter int txid_sz = 4,
    parameter int max_out = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       w_srdy,
    output logic                       w_drdy,
    input  logic [asz-1:0]             w_itemid,
    input  logic [width-1:0]           w_data,
    input  logic                       r_srdy,
    output logic                       r_drdy,
    input  logic [asz-1:0]             r_itemid,
    output logic                       pbrd_srdy,
    input  logic                       pbrd_drdy,
    output logic [1+txid_sz+asz+width-1:0] pbrd_data,
    output logic                       pbra_srdy,
    input  logic                       pbra_drdy,
    output logic [1+txid_sz+asz+width-1:0] pbra_data,
    input  logic                       pbrr_srdy,
    output logic                       pbrr_drdy,
    input  logic [txid_sz+width-1:0]   pbrr_data,
    output logic                       p_srdy,
    input  logic                       p_drdy,
    output logic [width-1:0]           p_data,
    output logic [asz-1:0]             p_itemid,
    output logic                       err
);

    localparam int rsz   = 1 + txid_sz + asz + width;
    localparam int idx_w = (max_out > 1) ? $clog2(max_out) : 1;
    localparam int cnt_w = idx_w + 1;

    // Comes up one edge after reset release, so all ready outputs stay low in reset.
    logic                 active_q, active_d;
    logic                 pbrd_srdy_q, pbrd_srdy_d;
    logic [rsz-1:0]       pbrd_data_q, pbrd_data_d;
    logic                 pbra_srdy_q, pbra_srdy_d;
    logic [rsz-1:0]       pbra_data_q, pbra_data_d;
    logic [idx_w-1:0]     head_q, head_d;
    logic [idx_w-1:0]     tail_q, tail_d;
    logic [cnt_w-1:0]     count_q, count_d;
    // busy: slot issued and not yet popped; valid: busy slot whose data has arrived.
    logic [max_out-1:0]   rob_busy_q, rob_busy_d;
    logic [max_out-1:0]   rob_valid_q, rob_valid_d;
    logic [asz-1:0]       rob_item_q [max_out];
    logic [asz-1:0]       rob_item_d [max_out];
    logic [width-1:0]     rob_data_q [max_out];
    logic [width-1:0]     rob_data_d [max_out];
    logic                 err_q, err_d;

    logic                 w_acc_s, r_acc_s, rsp_acc_s, pop_s;
    logic [txid_sz-1:0]   rsp_txid_s;
    logic [txid_sz-1:0]   issue_txid_s;
    logic [idx_w-1:0]     rsp_idx_s;
    logic [width-1:0]     rsp_data_s;
    logic                 rsp_in_range_s;
    logic                 rsp_ok_s;

    assign w_drdy    = active_q & (~pbrd_srdy_q | pbrd_drdy);
    assign r_drdy    = active_q & (count_q < cnt_w'(max_out)) & (~pbra_srdy_q | pbra_drdy);
    assign pbrr_drdy = active_q;
    assign pbrd_srdy = pbrd_srdy_q;
    assign pbrd_data = pbrd_data_q;
    assign pbra_srdy = pbra_srdy_q;
    assign pbra_data = pbra_data_q;
    assign p_srdy    = rob_valid_q[head_q];
    assign p_data    = rob_data_q[head_q];
    assign p_itemid  = rob_item_q[head_q];
    assign err       = err_q;

    assign w_acc_s   = w_srdy & w_drdy;
    assign r_acc_s   = r_srdy & r_drdy;
    assign rsp_acc_s = pbrr_srdy & pbrr_drdy;
    assign pop_s     = p_srdy & p_drdy;

    // Decode a response: it is only legal for an in-range txid whose slot is issued and unfilled.
    always_comb begin
        rsp_txid_s     = pbrr_data[width +: txid_sz];
        rsp_data_s     = pbrr_data[width-1:0];
        rsp_in_range_s = ({1'b0, rsp_txid_s} < (txid_sz + 1)'(max_out));
        rsp_idx_s      = rsp_txid_s[idx_w-1:0];
        rsp_ok_s       = rsp_in_range_s & rob_busy_q[rsp_idx_s] & ~rob_valid_q[rsp_idx_s];
    end

    // The txid of a new read is the tail slot index, zero-extended.
    always_comb begin
        issue_txid_s              = '0;
        issue_txid_s[idx_w-1:0]   = tail_q;
    end

    // Write and read output stages: load on accept, clear when taken, otherwise hold.
    always_comb begin
        active_d    = 1'b1;
        pbrd_srdy_d = pbrd_srdy_q;
        pbrd_data_d = pbrd_data_q;
        pbra_srdy_d = pbra_srdy_q;
        pbra_data_d = pbra_data_q;
        if (w_acc_s) begin
            pbrd_srdy_d = 1'b1;
            pbrd_data_d = {1'b1, {txid_sz{1'b0}}, w_itemid, w_data};
        end else if (pbrd_drdy) begin
            pbrd_srdy_d = 1'b0;
        end else begin
            pbrd_srdy_d = pbrd_srdy_q;
        end
        if (r_acc_s) begin
            pbra_srdy_d = 1'b1;
            pbra_data_d = {1'b0, issue_txid_s, r_itemid, {width{1'b0}}};
        end else if (pbra_drdy) begin
            pbra_srdy_d = 1'b0;
        end else begin
            pbra_srdy_d = pbra_srdy_q;
        end
    end

    // Reorder buffer: reserve at issue, fill on response, release at pop.
    always_comb begin
        rob_busy_d  = rob_busy_q;
        rob_valid_d = rob_valid_q;
        rob_item_d  = rob_item_q;
        rob_data_d  = rob_data_q;
        head_d      = head_q;
        tail_d      = tail_q;
        err_d       = err_q;
        if (r_acc_s) begin
            rob_item_d[tail_q]  = r_itemid;
            rob_valid_d[tail_q] = 1'b0;
            rob_busy_d[tail_q]  = 1'b1;
            tail_d              = tail_q + idx_w'(1);
        end else begin
            tail_d = tail_q;
        end
        if (rsp_acc_s && rsp_ok_s) begin
            rob_data_d[rsp_idx_s]  = rsp_data_s;
            rob_valid_d[rsp_idx_s] = 1'b1;
        end else if (rsp_acc_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
        // A pop always hits a filled slot, so it never collides with a legal fill or an issue.
        if (pop_s) begin
            rob_valid_d[head_q] = 1'b0;
            rob_busy_d[head_q]  = 1'b0;
            head_d              = head_q + idx_w'(1);
        end else begin
            head_d = head_q;
        end
        case ({r_acc_s, pop_s})
            2'b10:   count_d = count_q + cnt_w'(1);
            2'b01:   count_d = count_q - cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q    <= 1'b0;
            pbrd_srdy_q <= 1'b0;
            pbrd_data_q <= '0;
            pbra_srdy_q <= 1'b0;
            pbra_data_q <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rob_busy_q  <= '0;
            rob_valid_q <= '0;
            err_q       <= 1'b0;
            for (int i = 0; i < max_out; i++) begin
                rob_item_q[i] <= '0;
                rob_data_q[i] <= '0;
            end
        end else begin
            active_q    <= active_d;
            pbrd_srdy_q <= pbrd_srdy_d;
            pbrd_data_q <= pbrd_data_d;
            pbra_srdy_q <= pbra_srdy_d;
            pbra_data_q <= pbra_data_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rob_busy_q  <= rob_busy_d;
            rob_valid_q <= rob_valid_d;
            err_q       <= err_d;
            for (int i = 0; i < max_out; i++) begin
                rob_item_q[i] <= rob_item_d[i];
                rob_data_q[i] <= rob_data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_pbr_initiator.sv
// Testbench for pbr_initiator: directed scenarios followed by a randomized phase
// checked against a queue-based model of outstanding reads.
module tb_pbr_initiator;

    localparam int W = 64;
    localparam int A = 8;
    localparam int T = 4;
    localparam int M = 4;
    localparam int R = 1 + T + A + W;

    logic           clk = 1'b0;
    logic           reset;
    logic           w_srdy, w_drdy;
    logic [A-1:0]   w_itemid;
    logic [W-1:0]   w_data;
    logic           r_srdy, r_drdy;
    logic [A-1:0]   r_itemid;
    logic           pbrd_srdy, pbrd_drdy;
    logic [R-1:0]   pbrd_data;
    logic           pbra_srdy, pbra_drdy;
    logic [R-1:0]   pbra_data;
    logic           pbrr_srdy, pbrr_drdy;
    logic [T+W-1:0] pbrr_data;
    logic           p_srdy, p_drdy;
    logic [W-1:0]   p_data;
    logic [A-1:0]   p_itemid;
    logic           err;

    always #5 clk = ~clk;

    pbr_initiator #(.width(W), .asz(A), .txid_sz(T), .max_out(M)) dut (
        .clk(clk), .reset(reset),
        .w_srdy(w_srdy), .w_drdy(w_drdy), .w_itemid(w_itemid), .w_data(w_data),
        .r_srdy(r_srdy), .r_drdy(r_drdy), .r_itemid(r_itemid),
        .pbrd_srdy(pbrd_srdy), .pbrd_drdy(pbrd_drdy), .pbrd_data(pbrd_data),
        .pbra_srdy(pbra_srdy), .pbra_drdy(pbra_drdy), .pbra_data(pbra_data),
        .pbrr_srdy(pbrr_srdy), .pbrr_drdy(pbrr_drdy), .pbrr_data(pbrr_data),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data), .p_itemid(p_itemid),
        .err(err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: outstanding reads in issue order.
    typedef struct {
        logic [A-1:0] item;
        int           txid;
        bit           filled;
        logic [W-1:0] data;
    } ent_t;
    ent_t         q[$];
    int           m_tail;
    bit           m_wv, m_av;
    logic [R-1:0] m_wd, m_ad;
    int           unfilled[$];
    int           k;
    bit           exp_r, exp_w, exp_p;
    logic [W-1:0] rdata;
    logic [W-1:0] hold_data;
    ent_t         ne;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input int t, input logic [W-1:0] d);
        pbrr_srdy = 1'b1;
        pbrr_data = {T'(t), d};
        tick();
        pbrr_srdy = 1'b0;
    endtask

    task automatic issue(input logic [A-1:0] item, input int txid);
        r_srdy   = 1'b1;
        r_itemid = item;
        #1;
        chk("issue_r_drdy", 128'(r_drdy), 128'(1'b1));
        tick();
        r_srdy = 1'b0;
        chk("issue_pbra_srdy", 128'(pbra_srdy), 128'(1'b1));
        chk("issue_pbra_data", 128'(pbra_data), 128'({1'b0, T'(txid), item, 64'h0}));
    endtask

    initial begin
        reset = 1'b0;
        w_srdy = 1'b0; w_itemid = '0; w_data = '0;
        r_srdy = 1'b0; r_itemid = '0;
        pbrd_drdy = 1'b0; pbra_drdy = 1'b0;
        pbrr_srdy = 1'b0; pbrr_data = '0;
        p_drdy = 1'b0;
        #2;
        // Reset state
        chk("rst_w_drdy", 128'(w_drdy), 128'(1'b0));
        chk("rst_r_drdy", 128'(r_drdy), 128'(1'b0));
        chk("rst_pbrr_drdy", 128'(pbrr_drdy), 128'(1'b0));
        chk("rst_pbrd_srdy", 128'(pbrd_srdy), 128'(1'b0));
        chk("rst_pbra_srdy", 128'(pbra_srdy), 128'(1'b0));
        chk("rst_p_srdy", 128'(p_srdy), 128'(1'b0));
        chk("rst_p_data", 128'(p_data), 128'(64'h0));
        chk("rst_err", 128'(err), 128'(1'b0));
        tick();
        reset = 1'b1;
        #1;
        chk("rel_w_drdy_first", 128'(w_drdy), 128'(1'b0));
        tick();
        chk("act_w_drdy", 128'(w_drdy), 128'(1'b1));
        chk("act_r_drdy", 128'(r_drdy), 128'(1'b1));
        chk("act_pbrr_drdy", 128'(pbrr_drdy), 128'(1'b1));

        // 1: single write, held while pbrd_drdy=0
        w_srdy = 1'b1; w_itemid = 8'h12; w_data = 64'hA5; pbrd_drdy = 1'b0;
        tick();
        w_srdy = 1'b0;
        chk("wr_srdy", 128'(pbrd_srdy), 128'(1'b1));
        chk("wr_data", 128'(pbrd_data), 128'({1'b1, 4'h0, 8'h12, 64'hA5}));
        chk("wr_w_drdy_blocked", 128'(w_drdy), 128'(1'b0));
        tick(); tick();
        chk("wr_hold_srdy", 128'(pbrd_srdy), 128'(1'b1));
        chk("wr_hold_data", 128'(pbrd_data), 128'({1'b1, 4'h0, 8'h12, 64'hA5}));
        pbrd_drdy = 1'b1;
        #1;
        chk("wr_w_drdy_taken", 128'(w_drdy), 128'(1'b1));
        tick();
        chk("wr_cleared", 128'(pbrd_srdy), 128'(1'b0));
        pbrd_drdy = 1'b0;

        // 2: four reads, fifth stalls, responses out of order
        pbra_drdy = 1'b1;
        for (int i = 1; i <= 4; i++) issue(8'(i), i - 1);
        r_srdy = 1'b1; r_itemid = 8'h05;
        #1;
        chk("full_r_drdy", 128'(r_drdy), 128'(1'b0));
        tick();
        chk("full_r_drdy_2", 128'(r_drdy), 128'(1'b0));
        r_srdy = 1'b0;
        respond(3, 64'hD3);
        chk("rsp3_p_srdy", 128'(p_srdy), 128'(1'b0));
        respond(1, 64'hD1);
        chk("rsp1_p_srdy", 128'(p_srdy), 128'(1'b0));
        respond(0, 64'hD0);
        chk("rsp0_p_srdy", 128'(p_srdy), 128'(1'b1));
        chk("rsp0_p_itemid", 128'(p_itemid), 128'(8'h01));
        chk("rsp0_p_data", 128'(p_data), 128'(64'hD0));
        respond(2, 64'hD2);
        chk("rsp_err_clear", 128'(err), 128'(1'b0));

        // 4: port stalls 10 cycles, then drains back-to-back
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_p_srdy", 128'(p_srdy), 128'(1'b1));
            chk("stall_p_data", 128'(p_data), 128'(64'hD0));
        end
        p_drdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_p_srdy", 128'(p_srdy), 128'(1'b1));
            chk("drain_p_itemid", 128'(p_itemid), 128'(8'(i + 1)));
            chk("drain_p_data", 128'(p_data), 128'(64'hD0 + 64'(i)));
            tick();
        end
        p_drdy = 1'b0;
        chk("drain_empty", 128'(p_srdy), 128'(1'b0));

        // 3: response with nothing outstanding
        respond(2, 64'hBAD);
        chk("bad_err", 128'(err), 128'(1'b1));
        chk("bad_p_srdy", 128'(p_srdy), 128'(1'b0));
        tick();
        chk("bad_err_sticky", 128'(err), 128'(1'b1));

        // 5: pop and new read in the same cycle at count=4
        for (int i = 0; i < 4; i++) issue(8'h20 + 8'(i), i);
        respond(0, 64'hE0);
        chk("f5_p_srdy", 128'(p_srdy), 128'(1'b1));
        r_srdy = 1'b1; r_itemid = 8'h30; p_drdy = 1'b1;
        #1;
        chk("f5_r_drdy_full", 128'(r_drdy), 128'(1'b0));
        tick();
        p_drdy = 1'b0;
        chk("f5_r_drdy_freed", 128'(r_drdy), 128'(1'b1));
        tick();
        r_srdy = 1'b0;
        chk("f5_wrap_txid", 128'(pbra_data), 128'({1'b0, 4'h0, 8'h30, 64'h0}));

        // 6: reset mid-traffic with 2 reads outstanding and a write pending
        respond(1, 64'hE1);
        respond(2, 64'hE2);
        p_drdy = 1'b1;
        chk("f6_pop_a", 128'(p_itemid), 128'(8'h21));
        tick();
        chk("f6_pop_b", 128'(p_itemid), 128'(8'h22));
        tick();
        p_drdy = 1'b0;
        pbrd_drdy = 1'b0; w_srdy = 1'b1; w_itemid = 8'h77; w_data = 64'h1234;
        tick();
        w_srdy = 1'b0;
        chk("f6_wr_pending", 128'(pbrd_srdy), 128'(1'b1));
        chk("f6_err_before", 128'(err), 128'(1'b1));
        reset = 1'b0;
        #1;
        chk("f6_pbrd_srdy", 128'(pbrd_srdy), 128'(1'b0));
        chk("f6_pbra_srdy", 128'(pbra_srdy), 128'(1'b0));
        chk("f6_p_srdy", 128'(p_srdy), 128'(1'b0));
        chk("f6_err", 128'(err), 128'(1'b0));
        chk("f6_r_drdy", 128'(r_drdy), 128'(1'b0));
        chk("f6_pbrr_drdy", 128'(pbrr_drdy), 128'(1'b0));
        tick();
        reset = 1'b1;
        tick();
        issue(8'h40, 0);
        respond(0, 64'hF0);
        p_drdy = 1'b1;
        chk("f6_p_itemid", 128'(p_itemid), 128'(8'h40));
        chk("f6_p_data", 128'(p_data), 128'(64'hF0));
        tick();
        p_drdy = 1'b0;
        chk("f6_empty", 128'(p_srdy), 128'(1'b0));

        // Randomized traffic against the queue model
        m_tail = 1; m_wv = 1'b0; m_av = 1'b0; m_wd = '0; m_ad = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            r_srdy    = 1'($urandom);
            r_itemid  = 8'($urandom);
            w_srdy    = 1'($urandom);
            w_itemid  = 8'($urandom);
            w_data    = {$urandom, $urandom};
            pbra_drdy = ($urandom % 4) != 0;
            pbrd_drdy = ($urandom % 4) != 0;
            p_drdy    = 1'($urandom);
            unfilled.delete();
            foreach (q[i]) if (!q[i].filled) unfilled.push_back(i);
            k = -1;
            rdata = {$urandom, $urandom};
            if (unfilled.size() > 0 && ($urandom % 3) != 0) begin
                k = unfilled[$urandom % unfilled.size()];
                pbrr_srdy = 1'b1;
                pbrr_data = {T'(q[k].txid), rdata};
            end else begin
                pbrr_srdy = 1'b0;
            end
            #1;
            exp_r = (q.size() < M) && (!m_av || pbra_drdy);
            exp_w = !m_wv || pbrd_drdy;
            exp_p = (q.size() > 0) && q[0].filled;
            chk("rnd_r_drdy", 128'(r_drdy), 128'(exp_r));
            chk("rnd_w_drdy", 128'(w_drdy), 128'(exp_w));
            chk("rnd_pbra_srdy", 128'(pbra_srdy), 128'(m_av));
            chk("rnd_pbrd_srdy", 128'(pbrd_srdy), 128'(m_wv));
            chk("rnd_p_srdy", 128'(p_srdy), 128'(exp_p));
            chk("rnd_err", 128'(err), 128'(1'b0));
            if (m_av) chk("rnd_pbra_data", 128'(pbra_data), 128'(m_ad));
            if (m_wv) chk("rnd_pbrd_data", 128'(pbrd_data), 128'(m_wd));
            if (exp_p) begin
                hold_data = q[0].data;
                chk("rnd_p_data", 128'(p_data), 128'(hold_data));
                chk("rnd_p_itemid", 128'(p_itemid), 128'(q[0].item));
            end
            if (w_srdy && exp_w) begin
                m_wv = 1'b1;
                m_wd = {1'b1, 4'h0, w_itemid, w_data};
            end else if (pbrd_drdy) begin
                m_wv = 1'b0;
            end
            if (k >= 0) begin
                q[k].filled = 1'b1;
                q[k].data   = rdata;
            end
            if (exp_p && p_drdy) void'(q.pop_front());
            if (r_srdy && exp_r) begin
                ne.item = r_itemid; ne.txid = m_tail; ne.filled = 1'b0; ne.data = '0;
                q.push_back(ne);
                m_av = 1'b1;
                m_ad = {1'b0, T'(m_tail), r_itemid, 64'h0};
                m_tail = (m_tail + 1) % M;
            end else if (pbra_drdy) begin
                m_av = 1'b0;
            end
            tick();
        end
        r_srdy = 1'b0; w_srdy = 1'b0; pbrr_srdy = 1'b0; p_drdy = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
